// File: rtl/sc_useq_controller_if.sv
// Datapath-side bus of the microsequencer: program load port, start handshake,
// flags in, control word / upc / busy / done out.
interface sc_useq_controller_if #(
  parameter int DATAWIDTH_CONTROL = 20,
  parameter int UPROG_ADDRWIDTH   = 4,
  parameter int LOOPCOUNT_WIDTH   = 8
);
  localparam int UWORD = DATAWIDTH_CONTROL + 3 + UPROG_ADDRWIDTH;

  logic                         sc_useq_controller_uprogwrite_InHigh;
  logic [UPROG_ADDRWIDTH-1:0]   sc_useq_controller_uprogaddr_InBUS;
  logic [UWORD-1:0]             sc_useq_controller_uprogdata_InBUS;
  logic                         sc_useq_controller_start_InHigh;
  logic [LOOPCOUNT_WIDTH-1:0]   sc_useq_controller_loopcount_InBUS;
  logic                         sc_useq_controller_overflow_InLow;
  logic                         sc_useq_controller_carry_InLow;
  logic                         sc_useq_controller_negative_InLow;
  logic                         sc_useq_controller_zero_InLow;
  logic [DATAWIDTH_CONTROL-1:0] sc_useq_controller_control_OutBUS;
  logic [UPROG_ADDRWIDTH-1:0]   sc_useq_controller_upc_OutBUS;
  logic                         sc_useq_controller_busy_OutHigh;
  logic                         sc_useq_controller_done_OutHigh;

  modport master (
    output sc_useq_controller_uprogwrite_InHigh, sc_useq_controller_uprogaddr_InBUS,
           sc_useq_controller_uprogdata_InBUS, sc_useq_controller_start_InHigh,
           sc_useq_controller_loopcount_InBUS, sc_useq_controller_overflow_InLow,
           sc_useq_controller_carry_InLow, sc_useq_controller_negative_InLow,
           sc_useq_controller_zero_InLow,
    input  sc_useq_controller_control_OutBUS, sc_useq_controller_upc_OutBUS,
           sc_useq_controller_busy_OutHigh, sc_useq_controller_done_OutHigh
  );

  modport slave (
    input  sc_useq_controller_uprogwrite_InHigh, sc_useq_controller_uprogaddr_InBUS,
           sc_useq_controller_uprogdata_InBUS, sc_useq_controller_start_InHigh,
           sc_useq_controller_loopcount_InBUS, sc_useq_controller_overflow_InLow,
           sc_useq_controller_carry_InLow, sc_useq_controller_negative_InLow,
           sc_useq_controller_zero_InLow,
    output sc_useq_controller_control_OutBUS, sc_useq_controller_upc_OutBUS,
           sc_useq_controller_busy_OutHigh, sc_useq_controller_done_OutHigh
  );
endinterface

// File: rtl/sc_useq_controller.sv
// Microprogrammed datapath controller: writable program RAM, FETCH/EXEC sequencing,
// flag-conditional branches and a DJNZ loop counter behind a start/busy/done handshake.
module sc_useq_controller #(
  parameter int DATAWIDTH_CONTROL = 20,
  parameter int UPROG_DEPTH       = 16,
  parameter int UPROG_ADDRWIDTH   = 4,
  parameter int LOOPCOUNT_WIDTH   = 8,
  parameter logic [DATAWIDTH_CONTROL-1:0] CTRL_NOP = '0
) (
  input logic sc_useq_controller_CLOCK_50,
  input logic sc_useq_controller_RESET_InHigh,
  sc_useq_controller_if.slave bus
);
  localparam int UWORD = DATAWIDTH_CONTROL + 3 + UPROG_ADDRWIDTH;
  localparam logic [UPROG_ADDRWIDTH-1:0] UPC_LAST = UPROG_ADDRWIDTH'(UPROG_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {C_NEXT, C_JUMP, C_JZ, C_JN, C_JC, C_JV, C_DJNZ, C_HALT} cond_t;

  logic [UWORD-1:0]             r_ram [UPROG_DEPTH];
  state_t                       r_state, w_next;
  logic [UPROG_ADDRWIDTH-1:0]   r_upc;
  logic [UWORD-1:0]             r_ir;
  logic [LOOPCOUNT_WIDTH-1:0]   r_loop;

  cond_t                        w_cond;
  logic [UPROG_ADDRWIDTH-1:0]   w_tgt, w_tgt_wrap, w_upc_inc;
  logic [DATAWIDTH_CONTROL-1:0] w_ictrl, w_ctrl;
  logic                         w_taken, w_busy, w_done, w_wr_ok;

  assign w_cond     = cond_t'(r_ir[UWORD-1 -: 3]);
  assign w_tgt      = r_ir[DATAWIDTH_CONTROL +: UPROG_ADDRWIDTH];
  assign w_ictrl    = r_ir[DATAWIDTH_CONTROL-1:0];
  assign w_tgt_wrap = UPROG_ADDRWIDTH'(32'(w_tgt) % UPROG_DEPTH);
  assign w_upc_inc  = (r_upc == UPC_LAST) ? '0 : r_upc + 1'b1;
  assign w_wr_ok    = (r_state == S_IDLE) && bus.sc_useq_controller_uprogwrite_InHigh &&
                      (32'(bus.sc_useq_controller_uprogaddr_InBUS) < UPROG_DEPTH);

  // Flags are active-low; DJNZ jumps only while the decremented count stays non-zero.
  always_comb begin
    w_taken = 1'b0;
    case (w_cond)
      C_JUMP:  w_taken = 1'b1;
      C_JZ:    w_taken = !bus.sc_useq_controller_zero_InLow;
      C_JN:    w_taken = !bus.sc_useq_controller_negative_InLow;
      C_JC:    w_taken = !bus.sc_useq_controller_carry_InLow;
      C_JV:    w_taken = !bus.sc_useq_controller_overflow_InLow;
      C_DJNZ:  w_taken = (r_loop != '0) && (r_loop != LOOPCOUNT_WIDTH'(1));
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge sc_useq_controller_CLOCK_50 or posedge sc_useq_controller_RESET_InHigh) begin
    if (sc_useq_controller_RESET_InHigh) r_state <= S_IDLE;
    else                                 r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ctrl = CTRL_NOP;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.sc_useq_controller_start_InHigh) w_next = S_FETCH;
      S_FETCH: begin
        w_busy = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        w_busy = 1'b1;
        w_ctrl = w_ictrl;
        w_next = (w_cond == C_HALT) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sc_useq_controller_CLOCK_50 or posedge sc_useq_controller_RESET_InHigh) begin
    if (sc_useq_controller_RESET_InHigh) begin
      r_upc  <= '0;
      r_ir   <= '0;
      r_loop <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.sc_useq_controller_start_InHigh) begin
          r_upc  <= '0;
          r_loop <= bus.sc_useq_controller_loopcount_InBUS;
        end
        S_FETCH: r_ir <= r_ram[r_upc];
        S_EXEC: if (w_cond != C_HALT) begin
          r_upc <= w_taken ? w_tgt_wrap : w_upc_inc;
          if (w_cond == C_DJNZ && r_loop != '0) r_loop <= r_loop - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Program RAM has no reset so a loaded program survives a mid-run abort.
  always_ff @(posedge sc_useq_controller_CLOCK_50) begin
    if (w_wr_ok)
      r_ram[bus.sc_useq_controller_uprogaddr_InBUS] <= bus.sc_useq_controller_uprogdata_InBUS;
  end

  assign bus.sc_useq_controller_control_OutBUS = w_ctrl;
  assign bus.sc_useq_controller_upc_OutBUS     = r_upc;
  assign bus.sc_useq_controller_busy_OutHigh   = w_busy;
  assign bus.sc_useq_controller_done_OutHigh   = w_done;
endmodule
